// File: rtl/nibble_packer.sv
// Packs pairs of periodically captured nibbles into bytes and buffers them in a small FIFO.
// Latency: a byte is visible on out_data one cycle after the edge that captures its second nibble.
// Backpressure: out_ready stalls the FIFO; when full with no pop, new bytes are dropped and overflow sticks.
module nibble_packer #(
  parameter int PERIOD = 13,
  parameter int DEPTH  = 4
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic [3:0]               data_in,
  input  logic                     sample_en,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow
);

  localparam int CW = $clog2(PERIOD);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);
  localparam logic [AW:0]   FULL   = (AW + 1)'(DEPTH);

  logic [CW-1:0] cnt;
  logic          half;
  logic [3:0]    lo;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  logic       capture;
  logic       push;
  logic [7:0] push_byte;
  logic       pop;
  logic       accept;

  // A capture happens on the enabled edge where the down-counter has reached zero.
  assign capture   = sample_en && (cnt == '0);
  assign push      = capture && half;
  assign push_byte = {data_in, lo};

  // Outputs come from registered FIFO state only.
  assign out_valid = (fill != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;
  assign pop       = out_valid && out_ready;

  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign accept    = push && ((fill != FULL) || pop);

  // Capture cadence: count down while enabled, reload after each capture.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt <= RELOAD;
    end else if (sample_en) begin
      if (cnt == '0) begin
        cnt <= RELOAD;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Pair assembly: first nibble parks in lo until its partner arrives, even across disabled spans.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      half <= 1'b0;
      lo   <= 4'h0;
    end else if (capture) begin
      if (!half) begin
        lo   <= data_in;
        half <= 1'b1;
      end else begin
        half <= 1'b0;
      end
    end
  end

  // Byte storage: write at wr_ptr on an accepted push.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (accept) begin
      mem[wr_ptr] <= push_byte;
    end
  end

  // FIFO bookkeeping: pointers wrap naturally at DEPTH, fill tracked explicitly, drops flagged.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fill     <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
      if (push && !accept) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nibble_packer.sv
// Self-checking bench for nibble_packer: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed byte values and timings.
module tb_nibble_packer;

  localparam int PERIOD = 13;
  localparam int DEPTH  = 4;

  logic                   clk_in;
  logic                   rst;
  logic [3:0]             data_in;
  logic                   sample_en;
  logic [7:0]             out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] fill;
  logic                   overflow;

  nibble_packer #(.PERIOD(PERIOD), .DEPTH(DEPTH)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .data_in   (data_in),
    .sample_en (sample_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fill      (fill),
    .overflow  (overflow)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;
  bit run      = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: enabled edges counted since reset; every PERIOD-th one is a capture.
  int         m_en    = 0;
  int         cap_cnt = 0;
  bit         m_half  = 1'b0;
  logic [3:0] m_lo    = 4'h0;
  logic [7:0] m_q[$];
  bit         m_ovf   = 1'b0;

  always @(posedge clk_in or negedge rst) begin : model
    bit         do_pop;
    bit         do_push;
    logic [7:0] pb;
    if (!rst) begin
      m_en   = 0;
      m_half = 1'b0;
      m_lo   = 4'h0;
      m_q.delete();
      m_ovf  = 1'b0;
    end else begin
      do_pop  = (m_q.size() != 0) && out_ready;
      do_push = 1'b0;
      pb      = 8'h00;
      if (sample_en) begin
        m_en++;
        if (m_en % PERIOD == 0) begin
          cap_cnt++;
          if (m_half) begin
            do_push = 1'b1;
            pb      = {data_in, m_lo};
          end else begin
            m_lo = data_in;
          end
          m_half = !m_half;
        end
      end
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        if (m_q.size() < DEPTH) m_q.push_back(pb);
        else m_ovf = 1'b1;
      end
    end
  end

  function automatic bit next_cap();
    return ((m_en + 1) % PERIOD) == 0;
  endfunction

  // Every-cycle comparison of DUT outputs against the model.
  int max_fill = 0;
  int n_pops   = 0;
  always @(negedge clk_in) begin : compare
    bit         ev;
    logic [7:0] ed;
    if (run) begin
      ev = (m_q.size() != 0);
      ed = ev ? m_q[0] : 8'h00;
      chk("cmp_valid", out_valid, ev);
      chk("cmp_data", out_data, ed);
      chk("cmp_fill", fill, m_q.size());
      chk("cmp_overflow", overflow, m_ovf);
      if (int'(fill) > max_fill) max_fill = int'(fill);
      if (out_valid && out_ready) n_pops++;
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    sample_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_fill", fill, 0);
    chk("rst_overflow", overflow, 0);
    @(negedge clk_in);
    #2 rst = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic capture(input logic [3:0] n);
    int c0;
    c0 = cap_cnt;
    data_in   = n;
    sample_en = 1'b1;
    for (int i = 0; i < 4 * PERIOD && cap_cnt == c0; i++) cyc();
    chk("capture_timeout", (cap_cnt != c0), 1);
  endtask

  logic [7:0] got[$];
  task automatic drain();
    got.delete();
    sample_en = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (!out_valid) break;
      got.push_back(out_data);
      cyc();
    end
    out_ready = 1'b0;
  endtask

  initial begin : main
    logic [7:0] exp_a[4];
    logic [7:0] exp_b[4];
    bit         early;
    int         first;
    int         k;
    exp_a = '{8'h10, 8'h32, 8'h54, 8'h76};
    exp_b = '{8'h32, 8'h54, 8'h76, 8'h98};

    rst = 1'b1; sample_en = 1'b0; data_in = 4'h0; out_ready = 1'b0;
    @(negedge clk_in);
    do_reset();
    run = 1'b1;

    // Basic pair: 5 captured on edge 13, A on edge 26.
    out_ready = 1'b0; sample_en = 1'b1; data_in = 4'h5; early = 1'b0;
    for (int e = 1; e <= 26; e++) begin
      if (e == 14) data_in = 4'hA;
      cyc();
      if (e < 26 && out_valid) early = 1'b1;
    end
    chk("basic_early_valid", early, 0);
    chk("basic_valid", out_valid, 1);
    chk("basic_data", out_data, 8'hA5);
    chk("basic_fill", fill, 1);
    chk("basic_model", (m_q.size() == 1) ? m_q[0] : 8'hFF, 8'hA5);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("basic_pop_fill", fill, 0);
    chk("basic_pop_data", out_data, 8'h00);

    // Overflow: ten nibbles 0..9, fifth byte dropped.
    do_reset();
    out_ready = 1'b0;
    for (int n = 0; n < 10; n++) capture(4'(n));
    chk("ovf_fill", fill, 4);
    chk("ovf_flag", overflow, 1);
    drain();
    chk("ovf_drain_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("ovf_drain_byte", got[i], exp_a[i]);
    chk("ovf_sticky", overflow, 1);

    // Full FIFO with a pop on the same edge as the fifth push.
    do_reset();
    out_ready = 1'b0;
    for (int n = 0; n < 9; n++) capture(4'(n));
    chk("fullpop_pre_fill", fill, 4);
    data_in = 4'h9; sample_en = 1'b1; k = 0;
    while (!next_cap() && k < 100) begin cyc(); k++; end
    chk("fullpop_align", next_cap(), 1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("fullpop_fill", fill, 4);
    chk("fullpop_overflow", overflow, 0);
    chk("fullpop_head", out_data, 8'h32);
    drain();
    chk("fullpop_drain_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("fullpop_drain_byte", got[i], exp_b[i]);

    // Enable hold: 5 enabled, 20 disabled, then capture after 8 more enabled edges.
    do_reset();
    out_ready = 1'b0; data_in = 4'hC; sample_en = 1'b1;
    repeat (5) cyc();
    sample_en = 1'b0;
    repeat (20) cyc();
    chk("hold_no_valid", out_valid, 0);
    sample_en = 1'b1; first = 0;
    for (int e = 1; e <= 40 && first == 0; e++) begin
      if (e == 9) data_in = 4'h6;
      cyc();
      if (out_valid) first = e;
    end
    chk("hold_first_byte_edge", first, 21);
    chk("hold_byte", out_data, 8'h6C);

    // Reset mid-pair discards the parked nibble.
    do_reset();
    out_ready = 1'b0;
    capture(4'h3);
    do_reset();
    capture(4'h1);
    capture(4'h2);
    chk("midrst_fill", fill, 1);
    chk("midrst_data", out_data, 8'h21);
    chk("midrst_model", (m_q.size() == 1) ? m_q[0] : 8'hFF, 8'h21);

    // Pointer wrap: twelve pairs with the consumer always ready.
    do_reset();
    out_ready = 1'b1;
    max_fill = 0; n_pops = 0;
    for (int n = 0; n < 24; n++) capture(4'($urandom_range(0, 15)));
    cyc();
    chk("wrap_pops", n_pops, 12);
    chk("wrap_max_fill", max_fill, 1);
    chk("wrap_overflow", overflow, 0);

    // Random traffic with sporadic resets; the compare process does the checking.
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      sample_en = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      data_in   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 399) == 0) do_reset();
      else cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_packer.md
# nibble_packer

Downstream consumer of the 4-bit periodic sample stage. It re-times capture of that stage's 4-bit output on the same cadence, packs every two nibbles into a byte, and buffers bytes in a small FIFO. The FIFO drains through a valid/ready byte interface toward the host-side logic. Drops caused by FIFO overflow are reported through a sticky flag.

## Interface
- PERIOD, 13: cycles between nibble captures; legal range ≥2. Matches the upstream reload value (12) plus 1.
- DEPTH, 4: FIFO depth in bytes; must be a power of 2, ≥2.
- clk_in  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- data_in  input  4  nibble from the upstream sample stage.
- sample_en  input  1  when 1, the capture counter runs; when 0, it holds.
- out_data  output  8  byte at the FIFO head; 8'h00 when the FIFO is empty.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data when out_valid=1 and out_ready=1.
- fill  output  $clog2(DEPTH)+1  number of bytes currently in the FIFO.
- overflow  output  1  sticky; set when a byte is dropped; cleared only by reset.

## Operation
- Capture counter:
  - rst=0 loads PERIOD-1.
  - On each edge with sample_en=1: if counter≠0, decrement; if counter=0, capture data_in and reload PERIOD-1.
  - With sample_en=0 the counter holds and nothing is captured.
- Packing uses a `half` flag and a low-nibble register `lo`:
  - Capture with half=0: lo←data_in, half←1.
  - Capture with half=1: form byte {data_in, lo}, issue a push, half←0.
- FIFO:
  - Circular buffer of DEPTH bytes with read and write pointers.
  - Pointer wrap is modulo DEPTH; fill is tracked explicitly, or as pointer difference with an extra bit.
- Pop: occurs when out_valid=1 and out_ready=1. The read pointer advances and fill decrements.
- Push acceptance: a push is accepted if fill<DEPTH, or if a pop occurs in the same cycle.
- Simultaneous push and pop: both happen; fill is unchanged. This also applies when fill=DEPTH, and no drop occurs.
- Push with fill=DEPTH and no pop: the byte is discarded, overflow←1, and the pointers are unchanged.
- Pop when empty is impossible because out_valid=0; out_ready is ignored.
- Arithmetic: nibbles are concatenated without modification, with no carry or width growth. The byte is always {second, first}.

## Timing
- Reset values: out_valid=0, out_data=8'h00, fill=0, overflow=0, half=0, lo=0, counter=PERIOD-1, pointers=0.
- First capture occurs on the PERIOD-th enabled rising edge after reset release.
- out_valid rises in the cycle after the edge that captures the second nibble of a pair. Push-to-visibility latency is 1 cycle.
- out_data and fill reflect registered FIFO state only. There is no combinational path from data_in or sample_en to any output.
- out_valid and out_data depend only on registered state. The consumer may hold out_ready high indefinitely.
- Reset asserted mid-operation:
  - All state clears immediately (asynchronous).
  - A half-formed pair is discarded and buffered bytes are lost.
  - After reset release, the next pair starts fresh with half=0.
- sample_en toggling: a pair may span disabled periods. The lo nibble is retained until its partner is captured.

## Test plan
- Basic pair:
  - Stimulus: reset, release, sample_en=1, data_in=4'h5 through the 13th edge, then 4'hA through the 26th edge.
  - Response: out_valid=0 before the 26th edge. After it: out_valid=1, out_data=8'hA5, fill=1. One cycle with out_ready=1 returns fill=0 and out_data=8'h00.
- Overflow:
  - Stimulus: out_ready=0, 10 captures with data_in incrementing 0..9.
  - Response: bytes 8'h10, 8'h32, 8'h54, 8'h76 held with fill=4. The fifth byte 8'h98 is dropped and overflow=1. Draining then yields exactly 8'h10, 8'h32, 8'h54, 8'h76 in order, and overflow stays 1.
- Full with simultaneous pop:
  - Stimulus: fill=4; out_ready=1 held on the edge where the fifth byte is pushed.
  - Response: fill stays 4, overflow stays 0, and the new byte is read last.
- Enable hold:
  - Stimulus: sample_en=1 for 5 edges, 0 for 20 edges, then 1.
  - Response: the first capture occurs 8 enabled edges after re-enable, and no capture occurs while disabled.
- Reset mid-pair:
  - Stimulus: capture 4'h3, assert rst for 1 cycle, release, then capture 4'h1 and 4'h2.
  - Response: the only byte output is 8'h21, and all outputs are at reset values during rst=0.
- Pointer wrap:
  - Stimulus: out_ready=1, 12 consecutive pairs.
  - Response: all bytes appear in order with no loss, fill never exceeds 1, and overflow=0.
